// File: rtl/fixed_exp_argred_if.sv
// Handshake bundle for the exp argument-reduction stage: input stream (in_*) and
// result stream (out_*). The reducer uses the slave view; its driver uses master.
interface fixed_exp_argred_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_k;
  logic [9:0]  out_rem;

  modport master (
    output in_valid,
    output in_x,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_k,
    input  out_rem
  );

  modport slave (
    input  in_valid,
    input  in_x,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_k,
    output out_rem
  );
endinterface

// File: rtl/fixed_exp_argred.sv
// Iterative argument reduction x = k*ln2 + rem, 0 <= rem < ln2.
// One add/subtract of ln2 (Q0.15) per clock; rem is handed out in [2:-7] format.
module fixed_exp_argred (
  input  logic                 clk,
  input  logic                 rst,
  fixed_exp_argred_if.slave    bus
);

  localparam logic signed [20:0] Ln2Q15 = 21'sd22713;

  typedef enum logic [1:0] {StIdle, StReduce, StDone} state_e;

  state_e             state_q, state_d;
  logic signed [20:0] r_q, r_d;
  logic signed [6:0]  k_q, k_d;
  logic [6:0]         out_k_q, out_k_d;
  logic [6:0]         out_rem_q, out_rem_d;
  logic               out_valid_q, out_valid_d;
  logic               out_hs;

  // out_valid is registered one cycle behind DONE entry, so the result is
  // offered n+2 edges after the input handshake.
  assign out_hs        = out_valid_q && bus.out_ready;
  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_k     = out_k_q;
  assign bus.out_rem   = {3'b000, out_rem_q};

  // Next-state: load, one reduction step per cycle, then hold until consumed.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    k_d         = k_q;
    out_k_d     = out_k_q;
    out_rem_d   = out_rem_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          // Q.7 -> Q.15 with sign extension to 21 bits.
          r_d     = {bus.in_x[11], bus.in_x, 8'h00};
          k_d     = '0;
          state_d = StReduce;
        end
      end
      StReduce: begin
        if (r_q < 0) begin
          r_d = r_q + Ln2Q15;
          k_d = k_q - 7'sd1;
        end else if (r_q >= Ln2Q15) begin
          r_d = r_q - Ln2Q15;
          k_d = k_q + 7'sd1;
        end else begin
          // Truncate the 15-bit fraction to 7 bits; no rounding.
          out_k_d   = k_q;
          out_rem_d = r_q[14:8];
          state_d   = StDone;
        end
      end
      StDone: begin
        out_valid_d = 1'b1;
        if (out_hs) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; reset discards any in-flight argument.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      r_q         <= '0;
      k_q         <= '0;
      out_k_q     <= '0;
      out_rem_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      k_q         <= k_d;
      out_k_q     <= out_k_d;
      out_rem_q   <= out_rem_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
